freq_mult_param: RTL and testbench
==================================

Name: freq_mult_param

Overview:
- Parametrised, next-generation frequency multiplier.
- Measures the period of a slow input clock f_in in reference-clock cycles, then derives a half-period divisor k for a multiplier M = 2^n.
- Generates f_out at M times the input frequency from a reloadable down-counter and toggle flop.
- Adds over the previous generation: configurable widths, an input synchroniser, error detection (too fast / stuck input), and a continuous tracking mode that re-measures while running without dropping valid.

Parameters:
- CNT_W, 16: width of the period counter, period and k.
- N_W, 3: width of the n (log2 multiplier) input.
- SYNC_STAGES, 2: flops in the f_in synchroniser; minimum 2.

Ports:
- clk  input  1  reference clock; all logic on the rising edge.
- rst  input  1  synchronous, active-low reset.
- f_in  input  1  clock to be multiplied; asynchronous to clk.
- adjust  input  1  one-cycle pulse; starts or restarts a measurement.
- n  input  N_W  multiplier exponent, M = 2^n; sampled in CALC.
- track  input  1  1 = continuous re-measurement in RUN.
- valid  output  1  f_out is locked to a measured k.
- f_out  output  1  multiplied clock.
- k  output  CNT_W  active half-period divisor.
- period  output  CNT_W  last measured f_in period, in clk cycles.
- err  output  1  measurement failed.
- cur_state  output  3  encoding: IDLE=0, WAIT_EDGE=1, MEASURE=2, CALC=3, RUN=4, ERR=5.

Behaviour:
- Reset (rst==0 at a clk edge):
  - cur_state=IDLE; valid=0, f_out=0, k=0, period=0, err=0.
  - Synchroniser, counters and pending-k cleared.
  - Reset has priority over every other event, including in the middle of a measurement or in RUN.
- Edge detect: a rise is flagged when the synchronised f_in is 1 and was 0 on the previous cycle. The synchroniser latency cancels out in period.
- IDLE: adjust -> WAIT_EDGE with cnt=0.
- WAIT_EDGE:
  - cnt increments each cycle.
  - On a rise: cnt<=1 -> MEASURE.
  - cnt reaching 2^CNT_W-1 -> ERR (stuck input).
- MEASURE:
  - cnt increments each cycle with no rise.
  - On a rise: period<=cnt -> CALC. A steady f_in period of P clk cycles therefore gives period=P.
  - cnt at max -> ERR.
  - adjust -> WAIT_EDGE, cnt=0.
- CALC (1 cycle):
  - kn = period >> (n+1).
  - kn==0 -> ERR.
  - Otherwise k<=kn -> RUN.
- RUN:
  - On entry: valid=1, f_out=0, div=k.
  - div decrements each cycle; at div==1, f_out toggles and div reloads from k.
  - Result: f_out period = 2k clk cycles, first toggle k cycles after entry.
  - adjust with track=0: valid=0, f_out=0 -> WAIT_EDGE.
- RUN with track=1:
  - A background counter measures between successive rises using the same counting rules as MEASURE.
  - On each rise: period updates and kn is computed with the current n.
  - If kn!=0, kn becomes pending and is loaded into k at the next reload (div==1). Any f_out phase is never shortened mid-phase.
  - valid stays 1 throughout.
  - kn==0 or background counter overflow -> ERR.
  - adjust restarts the measurement as in track=0.
- ERR: err=1, valid=0, f_out=0, k holds. adjust -> WAIT_EDGE with err cleared.
- Width rules:
  - All counters are unsigned CNT_W and never wrap; overflow is detected at all-ones.
  - n is zero-extended before the shift.
  - A shift of CNT_W or more yields 0, which leads to ERR.
- Simultaneous events:
  - adjust and a rise in the same cycle: adjust wins.
  - track toggled in RUN takes effect at the next rise.

Optional Feature:
- Macro: FREQ_MULT_ROUND_EN.
- Defined: kn = (period + 2^n) >> (n+1), round-to-nearest, computed at CNT_W+1 bits to avoid overflow.
- Undefined: kn = period >> (n+1), truncation.
- All other behaviour is identical in both builds.

Test Plan:
- f_in period 64 clk, n=2, adjust pulse -> period=64, k=8, valid=1, f_out period 16 clk; first toggle 8 cycles after RUN entry.
- f_in period 10, n=0 -> k=5, f_out period 10.
- f_in period 3, n=2 -> kn=0 -> cur_state=ERR, err=1, valid=0; a later adjust with period 64 recovers to k=8.
- CNT_W=8, f_in held 0 after adjust -> ERR after 255 cycles; a rise, then f_in stuck high -> ERR from MEASURE.
- track=1, n=2, period changes 64 -> 128 -> k changes 8 -> 16 exactly at a reload, valid never drops, no f_out phase shorter than 8.
- Period 70, n=2 -> k=8 without FREQ_MULT_ROUND_EN, k=9 with it.
- rst low mid-RUN -> next cycle all outputs at reset values, cur_state=0.

Source files
------------

// File: rtl/freq_mult_param.sv
// Frequency multiplier: measures the f_in period in clk cycles and runs a divider at 2^n times f_in.
// Define FREQ_MULT_ROUND_EN for round-to-nearest divisor; default build truncates.
module freq_mult_param #(
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned N_W         = 3,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             f_in,
    input  logic             adjust,
    input  logic [N_W-1:0]   n,
    input  logic             track,
    output logic             valid,
    output logic             f_out,
    output logic [CNT_W-1:0] k,
    output logic [CNT_W-1:0] period,
    output logic             err,
    output logic [2:0]       cur_state
);

    localparam int unsigned     SYNC_N  = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
`ifdef FREQ_MULT_ROUND_EN
    localparam logic [CNT_W:0]   ONE_W   = {{CNT_W{1'b0}}, 1'b1};
`endif

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_EDGE = 3'd1,
        MEASURE   = 3'd2,
        CALC      = 3'd3,
        RUN       = 3'd4,
        ERR       = 3'd5
    } state_t;

    state_t            state_q, state_d;
    logic [SYNC_N-1:0] sync_q, sync_d;
    logic              prev_q, prev_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  div_q, div_d;
    logic [CNT_W-1:0]  k_q, k_d;
    logic [CNT_W-1:0]  period_q, period_d;
    logic [CNT_W-1:0]  pend_k_q, pend_k_d;
    logic              pend_v_q, pend_v_d;
    logic              armed_q, armed_d;
    logic              valid_q, valid_d;
    logic              f_out_q, f_out_d;
    logic              err_q, err_d;

    logic              rise;
    logic [CNT_W-1:0]  cnt_inc;
    logic              cnt_ovf;
    logic [CNT_W-1:0]  kn_calc;
    logic [CNT_W-1:0]  kn_trk;
    logic              go_err;

    // Half-period divisor; any shift of CNT_W or more is forced to zero so it always ends in ERR.
    function automatic logic [CNT_W-1:0] calc_kn(input logic [CNT_W-1:0] p,
                                                  input logic [N_W-1:0]   nn);
        logic [CNT_W:0] num;
        logic [CNT_W:0] shifted;
        logic [31:0]    sh;
        sh = 32'(nn) + 32'd1;
`ifdef FREQ_MULT_ROUND_EN
        num = {1'b0, p} + (ONE_W << nn);
`else
        num = {1'b0, p};
`endif
        shifted = num >> sh;
        if (sh >= CNT_W) calc_kn = '0;
        else             calc_kn = shifted[CNT_W-1:0];
    endfunction

    assign rise    = sync_q[SYNC_N-1] & ~prev_q;
    assign cnt_inc = cnt_q + CNT_ONE;
    assign cnt_ovf = (cnt_inc == CNT_MAX);
    assign kn_calc = calc_kn(period_q, n);
    assign kn_trk  = calc_kn(cnt_q, n);

    always_comb begin
        state_d  = state_q;
        sync_d   = {sync_q[SYNC_N-2:0], f_in};
        prev_d   = sync_q[SYNC_N-1];
        cnt_d    = cnt_q;
        div_d    = div_q;
        k_d      = k_q;
        period_d = period_q;
        pend_k_d = pend_k_q;
        pend_v_d = pend_v_q;
        armed_d  = armed_q;
        valid_d  = valid_q;
        f_out_d  = f_out_q;
        err_d    = err_q;
        go_err   = 1'b0;

        if (adjust) begin
            // adjust restarts from any state and outranks a coincident rise
            state_d  = WAIT_EDGE;
            cnt_d    = '0;
            valid_d  = 1'b0;
            f_out_d  = 1'b0;
            err_d    = 1'b0;
            pend_v_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: ;
                WAIT_EDGE: begin
                    if (rise) begin
                        cnt_d   = CNT_ONE;
                        state_d = MEASURE;
                    end else if (cnt_ovf) begin
                        go_err = 1'b1;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                MEASURE: begin
                    if (rise) begin
                        period_d = cnt_q;
                        cnt_d    = CNT_ONE;
                        state_d  = CALC;
                    end else if (cnt_ovf) begin
                        go_err = 1'b1;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                CALC: begin
                    if (rise)                  cnt_d = CNT_ONE;
                    else if (cnt_q != CNT_MAX) cnt_d = cnt_inc;
                    if (kn_calc == '0) begin
                        go_err = 1'b1;
                    end else begin
                        k_d      = kn_calc;
                        div_d    = kn_calc;
                        valid_d  = 1'b1;
                        f_out_d  = 1'b0;
                        pend_v_d = 1'b0;
                        armed_d  = track;
                        state_d  = RUN;
                    end
                end
                RUN: begin
                    if (div_q == CNT_ONE) begin
                        f_out_d = ~f_out_q;
                        if (pend_v_q) begin
                            k_d      = pend_k_q;
                            div_d    = pend_k_q;
                            pend_v_d = 1'b0;
                        end else begin
                            div_d = k_q;
                        end
                    end else begin
                        div_d = div_q - CNT_ONE;
                    end
                    // Background period count; track is latched at each rise so it acts from the next one.
                    if (rise) begin
                        cnt_d   = CNT_ONE;
                        armed_d = track;
                        if (armed_q) begin
                            period_d = cnt_q;
                            if (kn_trk == '0) begin
                                go_err = 1'b1;
                            end else begin
                                pend_k_d = kn_trk;
                                pend_v_d = 1'b1;
                            end
                        end
                    end else if (armed_q && cnt_ovf) begin
                        go_err = 1'b1;
                    end else if (cnt_q != CNT_MAX) begin
                        cnt_d = cnt_inc;
                    end
                end
                ERR: ;
                default: state_d = IDLE;
            endcase

            if (go_err) begin
                state_d  = ERR;
                err_d    = 1'b1;
                valid_d  = 1'b0;
                f_out_d  = 1'b0;
                pend_v_d = 1'b0;
                k_d      = k_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= IDLE;
            sync_q   <= '0;
            prev_q   <= 1'b0;
            cnt_q    <= '0;
            div_q    <= '0;
            k_q      <= '0;
            period_q <= '0;
            pend_k_q <= '0;
            pend_v_q <= 1'b0;
            armed_q  <= 1'b0;
            valid_q  <= 1'b0;
            f_out_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            sync_q   <= sync_d;
            prev_q   <= prev_d;
            cnt_q    <= cnt_d;
            div_q    <= div_d;
            k_q      <= k_d;
            period_q <= period_d;
            pend_k_q <= pend_k_d;
            pend_v_q <= pend_v_d;
            armed_q  <= armed_d;
            valid_q  <= valid_d;
            f_out_q  <= f_out_d;
            err_q    <= err_d;
        end
    end

    assign valid     = valid_q;
    assign f_out     = f_out_q;
    assign k         = k_q;
    assign period    = period_q;
    assign err       = err_q;
    assign cur_state = state_q;

endmodule

// File: tb/tb_freq_mult_param.sv
// Self-checking bench for freq_mult_param: table-driven lock vectors through a scoreboard queue,
// plus tracking, mid-run reset and CNT_W=8 stuck-input sequences.
module tb_freq_mult_param;

    logic        clk = 1'b0;
    logic        rst;
    logic        adjust_a, track_a, f_in_a;
    logic [2:0]  n_a;
    logic        valid_a, f_out_a, err_a;
    logic [15:0] k_a, period_a;
    logic [2:0]  cur_state_a;

    logic        adjust_b, track_b, f_in_b;
    logic [2:0]  n_b;
    logic        valid_b, f_out_b, err_b;
    logic [7:0]  k_b, period_b;
    logic [2:0]  cur_state_b;

    always #5 clk = ~clk;

    freq_mult_param #(.CNT_W(16), .N_W(3), .SYNC_STAGES(2)) dut_a (
        .clk(clk), .rst(rst), .f_in(f_in_a), .adjust(adjust_a), .n(n_a), .track(track_a),
        .valid(valid_a), .f_out(f_out_a), .k(k_a), .period(period_a), .err(err_a),
        .cur_state(cur_state_a)
    );

    freq_mult_param #(.CNT_W(8), .N_W(3), .SYNC_STAGES(3)) dut_b (
        .clk(clk), .rst(rst), .f_in(f_in_b), .adjust(adjust_b), .n(n_b), .track(track_b),
        .valid(valid_b), .f_out(f_out_b), .k(k_b), .period(period_b), .err(err_b),
        .cur_state(cur_state_b)
    );

    typedef struct {
        int per;
        int nn;
        int e_period;
        int e_k;
        int e_err;
    } vec_t;

    vec_t tbl[5];
    vec_t sb_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   fin_per = 0;
    int   fin_rises = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
        end
    endtask

    // f_in for dut_a: exact period of fin_per clk cycles, edges 3 time units after posedge
    initial begin
        f_in_a = 1'b0;
        forever begin
            int p;
            @(posedge clk); #3;
            p = fin_per;
            if (p >= 2) begin
                f_in_a = 1'b1;
                fin_rises++;
                repeat (p / 2) begin @(posedge clk); #3; end
                f_in_a = 1'b0;
                repeat (p - p / 2 - 1) begin @(posedge clk); #3; end
            end else begin
                f_in_a = 1'b0;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic wait_fin_rise();
        int r0;
        r0 = fin_rises;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (fin_rises != r0) return;
        end
        chk("fin_rise_timeout", 32'd0, 32'd1);
    endtask

    task automatic pulse_adjust_a();
        adjust_a = 1'b1;
        @(negedge clk);
        adjust_a = 1'b0;
    endtask

    task automatic wait_lock_a(output bit got);
        got = 1'b0;
        for (int c = 0; c < 1500; c++) begin
            if (valid_a || err_a) begin
                got = 1'b1;
                return;
            end
            @(negedge clk);
        end
    endtask

    task automatic check_reset_a(input string tag);
        chk({tag, "_valid"},  32'(valid_a), 32'd0);
        chk({tag, "_f_out"},  32'(f_out_a), 32'd0);
        chk({tag, "_k"},      32'(k_a), 32'd0);
        chk({tag, "_period"}, 32'(period_a), 32'd0);
        chk({tag, "_err"},    32'(err_a), 32'd0);
        chk({tag, "_state"},  32'(cur_state_a), 32'd0);
    endtask

    // Called at the first sample in RUN: first toggle after k cycles, then k high and k low.
    task automatic check_fout(input int kk, input string tag);
        int cyc, h, l;
        chk({tag, "_fout_entry"}, 32'(f_out_a), 32'd0);
        cyc = 0;
        while (!f_out_a && cyc < 2000) begin @(negedge clk); cyc++; end
        chk({tag, "_first_toggle"}, 32'(cyc), 32'(kk));
        h = 1;
        for (int i = 0; i < 2000; i++) begin @(negedge clk); if (f_out_a) h++; else break; end
        l = 1;
        for (int i = 0; i < 2000; i++) begin @(negedge clk); if (!f_out_a) l++; else break; end
        chk({tag, "_half_period"}, 32'(h), 32'(kk));
        chk({tag, "_full_period"}, 32'(h + l), 32'(2 * kk));
    endtask

    initial begin
        vec_t e;
        bit   got;
        int   prev_k, run, k_changes, k_off_edge, bad_run, valid_drop, c;
        logic prev_f;
        bit   saw_measure;

        rst = 1'b0; adjust_a = 1'b0; track_a = 1'b0; n_a = 3'd0;
        adjust_b = 1'b0; track_b = 1'b0; n_b = 3'd0; f_in_b = 1'b0;

        tbl[0] = '{per: 64, nn: 2, e_period: 64, e_k: 8, e_err: 0};
        tbl[1] = '{per: 10, nn: 0, e_period: 10, e_k: 5, e_err: 0};
        tbl[2] = '{per: 3,  nn: 2, e_period: 3,  e_k: 5, e_err: 1};
        tbl[3] = '{per: 64, nn: 2, e_period: 64, e_k: 8, e_err: 0};
`ifdef FREQ_MULT_ROUND_EN
        tbl[4] = '{per: 70, nn: 2, e_period: 70, e_k: 9, e_err: 0};
`else
        tbl[4] = '{per: 70, nn: 2, e_period: 70, e_k: 8, e_err: 0};
`endif

        repeat (4) @(negedge clk);
        check_reset_a("rst0");
        chk("rst0_b_state",  32'(cur_state_b), 32'd0);
        chk("rst0_b_valid",  32'(valid_b), 32'd0);
        chk("rst0_b_fout",   32'(f_out_b), 32'd0);
        chk("rst0_b_k",      32'(k_b), 32'd0);
        chk("rst0_b_period", 32'(period_b), 32'd0);
        chk("rst0_b_err",    32'(err_b), 32'd0);
        rst = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            string tag;
            tag = $sformatf("v%0d", i);
            fin_per = tbl[i].per;
            n_a = 3'(tbl[i].nn);
            wait_fin_rise();
            sb_q.push_back(tbl[i]);
            pulse_adjust_a();
            wait_lock_a(got);
            e = sb_q.pop_front();
            chk({tag, "_done"}, 32'(got), 32'd1);
            if (got) begin
                chk({tag, "_period"}, 32'(period_a), 32'(e.e_period));
                chk({tag, "_k"},      32'(k_a), 32'(e.e_k));
                chk({tag, "_err"},    32'(err_a), 32'(e.e_err));
                chk({tag, "_valid"},  32'(valid_a), 32'(1 - e.e_err));
                chk({tag, "_state"},  32'(cur_state_a), (e.e_err != 0) ? 32'd5 : 32'd4);
                if (e.e_err == 0) check_fout(e.e_k, tag);
            end
        end

        // Tracking: period steps 64 -> 128 while running, k must move 8 -> 16 only at a reload.
        track_a = 1'b1;
        n_a = 3'd2;
        fin_per = 64;
        wait_fin_rise();
        pulse_adjust_a();
        wait_lock_a(got);
        chk("trk_lock", 32'(valid_a), 32'd1);
        chk("trk_k0", 32'(k_a), 32'd8);
        fin_per = 128;
        prev_k = int'(k_a); prev_f = f_out_a; run = 1;
        k_changes = 0; k_off_edge = 0; bad_run = 0; valid_drop = 0;
        for (int i = 0; i < 900; i++) begin
            @(negedge clk);
            if (!valid_a) valid_drop++;
            if (int'(k_a) != prev_k) begin
                k_changes++;
                if (f_out_a == prev_f) k_off_edge++;
            end
            if (f_out_a != prev_f) begin
                if (run != 8 && run != 16) bad_run++;
                run = 1;
            end else begin
                run++;
            end
            prev_k = int'(k_a);
            prev_f = f_out_a;
        end
        chk("trk_valid_drops", 32'(valid_drop), 32'd0);
        chk("trk_k_changes", 32'(k_changes), 32'd1);
        chk("trk_k_change_off_reload", 32'(k_off_edge), 32'd0);
        chk("trk_bad_phase", 32'(bad_run), 32'd0);
        chk("trk_k_final", 32'(k_a), 32'd16);
        chk("trk_period_final", 32'(period_a), 32'd128);
        chk("trk_state", 32'(cur_state_a), 32'd4);

        rst = 1'b0;
        @(negedge clk);
        check_reset_a("rst_run");
        rst = 1'b1;
        track_a = 1'b0;
        fin_per = 0;

        // CNT_W=8, f_in low: WAIT_EDGE entered at the first posedge, ERR 255 cycles later.
        @(negedge clk);
        adjust_b = 1'b1;
        c = 0;
        for (int i = 1; i <= 400; i++) begin
            @(negedge clk);
            adjust_b = 1'b0;
            if (cur_state_b == 3'd5) begin c = i; break; end
        end
        chk("b_stuck_low_cycles", 32'(c), 32'd256);
        chk("b_stuck_low_err", 32'(err_b), 32'd1);
        chk("b_stuck_low_valid", 32'(valid_b), 32'd0);

        // Rise then stuck high: 3-stage sync flags the rise 3 edges in, then MEASURE overflows.
        adjust_b = 1'b1;
        f_in_b = 1'b1;
        c = 0;
        saw_measure = 1'b0;
        for (int i = 1; i <= 400; i++) begin
            @(negedge clk);
            adjust_b = 1'b0;
            if (cur_state_b == 3'd2) saw_measure = 1'b1;
            if (cur_state_b == 3'd5) begin c = i; break; end
        end
        chk("b_stuck_high_measure", 32'(saw_measure), 32'd1);
        chk("b_stuck_high_cycles", 32'(c), 32'd258);
        chk("b_stuck_high_err", 32'(err_b), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
